sdio_host_cmd_phy: RTL and testbench
====================================

// Module: sdio_host_cmd_phy
// PURPOSE
//  Host-side SDIO CMD-line PHY, the initiator for the device command PHY. Serialises a 48-bit
//  command frame (start, dir=1, index, argument, CRC7, end) onto the CMD line. Then releases
//  the line and captures the device response: start, dir=0, payload, CRC7, end.
//  Reports CRC, framing and timeout status. Sits between the host link layer and the pad/IO cell.
// PARAMETERS
//  RSP_TIMEOUT  64  cycles to wait (after turnaround) for a response start bit before timing out
// PORTS
//  sdio_clk        in   1    SDIO clock; all logic on posedge
//  rst             in   1    synchronous, active-high reset
//  cmd_stb         in   1    start command; sampled only in IDLE, ignored otherwise
//  cmd             in   6    command index
//  cmd_arg         in   32   command argument
//  rsps_len        in   8    response payload bits between dir bit and CRC (0 = no response; R1=38, R2=127)
//  rsps_crc_en     in   1    1: check response CRC7; 0: skip (R2/R3)
//  busy            out  1    high whenever state != IDLE
//  done_stb        out  1    one-cycle pulse at end of transaction
//  rsps            out  128  response payload, right-justified, upper bits zero
//  rsps_crc_good   out  1    response CRC matched (forced 1 when rsps_crc_en=0)
//  rsps_frame_err  out  1    dir bit received as 1 or end bit received as 0
//  rsps_timeout    out  1    no start bit within RSP_TIMEOUT cycles
//  sdio_cmd_in     in   1    CMD line input
//  sdio_cmd_out    out  1    CMD line drive value
//  sdio_cmd_dir    out  1    1 = host drives CMD
// BEHAVIOUR
//  Reset: state=IDLE, sdio_cmd_out=1, sdio_cmd_dir=0, busy=0, done_stb=0, rsps=0, status flags=0.
//  Reset mid-operation aborts at once, releases the line, and emits no done_stb.
//  CRC7: polynomial x^7+x^3+1, initial value 0, computed inline bit-serially over the frame
//   bits that precede the CRC. The command CRC is sent MSB first.
//  Command latch: on cmd_stb in IDLE, latch cmd/cmd_arg/rsps_len/rsps_crc_en into a 40-bit shift
//   register {0,1,cmd,cmd_arg}. Clear rsps and all status flags.
//  All outputs are registered. The start bit appears on sdio_cmd_out with sdio_cmd_dir=1 in the
//   cycle after cmd_stb is sampled.
//  States:
//   IDLE      out=1, dir=0. On cmd_stb -> TX_CMD.
//   TX_CMD    drive 40 bits MSB first (1 bit/cycle) -> TX_CRC.
//   TX_CRC    drive 7 CRC bits -> TX_END.
//   TX_END    drive 1 for one cycle. Next cycle dir=0.
//             If rsps_len==0: done_stb, go to IDLE. Otherwise go to RSP_WAIT.
//   RSP_WAIT  the first cycle after release is turnaround and is not sampled. Then the timeout
//             counter increments each cycle.
//             sdio_cmd_in==0 -> RSP_DIR. Restart the CRC on this bit and include it.
//             If the counter reaches RSP_TIMEOUT: rsps_timeout=1, done_stb, go to IDLE.
//   RSP_DIR   sample the dir bit; if 1, set rsps_frame_err (reception continues) -> RSP_DATA.
//   RSP_DATA  shift sdio_cmd_in into rsps LSB, rsps_len bits -> RSP_CRC.
//   RSP_CRC   shift in 7 bits -> RSP_END.
//   RSP_END   sample the end bit (0 sets rsps_frame_err). Compare the received CRC with the
//             computed CRC to set rsps_crc_good. done_stb, go to IDLE.
//  Status flags and rsps hold from done_stb until the next accepted cmd_stb.
//  Bit counter: 8 bits, cleared on each state entry. rsps_len values above 127 are clamped to 127.
//  cmd_stb asserted together with done_stb is ignored, because the block is not yet in IDLE.
//  A new cmd_stb is accepted the cycle after done_stb.
// TESTING
//  1. CMD0, arg 0, rsps_len=0 -> line carries 0x40_00000000_95 MSB first, dir=1 for 48 cycles;
//     done_stb 1 cycle after end bit; all flags 0.
//  2. CMD8, arg 0x000001AA, rsps_len=38; device model returns R7 0x08_000001AA with a correct CRC
//     -> TX frame ends 0x87; rsps=0x08000001AA, rsps_crc_good=1, rsps_frame_err=0.
//  3. As test 2, but the model flips one CRC bit -> rsps_crc_good=0, rsps same payload, done_stb.
//  4. CMD55, rsps_len=38, CMD line held high -> rsps_timeout=1 and done_stb exactly
//     RSP_TIMEOUT+1 cycles after release.
//  5. R2 (rsps_len=127, rsps_crc_en=0) and a response with dir bit=1
//     -> 127-bit payload captured, rsps_crc_good=1, rsps_frame_err=1.
//  6. rst asserted mid-TX_CMD and mid-RSP_DATA -> next cycle out=1, dir=0, busy=0, no done_stb;
//     cmd_stb pulses while busy are ignored.

Source files
------------

// File: rtl/sdio_host_cmd_phy.sv
// sdio_host_cmd_phy
//   Host-side SDIO CMD-line PHY. Shifts a 48-bit command frame
//   {start, dir=1, index, argument, CRC7, end} out on the CMD line, then releases
//   the line and captures the device response {start, dir=0, payload, CRC7, end}.
//   It reports CRC, framing and timeout status for the link layer above.
//
// Ports
//   sdio_clk_i         SDIO clock; all logic runs on its rising edge
//   rst_i              synchronous, active-high reset
//   cmd_stb_i          start a command; only looked at while idle
//   cmd_i[5:0]         command index
//   cmd_arg_i[31:0]    command argument
//   rsps_len_i[7:0]    response payload bits (0 = no response); values >127 clamp to 127
//   rsps_crc_en_i      check the response CRC7 (0 for R2/R3)
//   busy_o             transaction in progress
//   done_stb_o         one-cycle pulse when a transaction ends
//   rsps_o[127:0]      response payload, right-justified
//   rsps_crc_good_o    response CRC matched (forced 1 when checking is disabled)
//   rsps_frame_err_o   response dir bit was 1 or end bit was 0
//   rsps_timeout_o     no response start bit arrived in time
//   sdio_cmd_in_i      CMD line input from the pad
//   sdio_cmd_out_o     CMD line drive value
//   sdio_cmd_dir_o     1 = host drives the CMD line
//
// State      | meaning
// IDLE       | line released and high, waiting for cmd_stb
// TX_CMD     | driving start, dir and 38 bits of index/argument
// TX_CRC     | driving the 7 command CRC bits, MSB first
// TX_END     | driving the end bit
// RSP_WAIT   | line released; one turnaround cycle, then hunting for a start bit
// RSP_DIR    | dir bit of the response on the line
// RSP_DATA   | response payload bits on the line
// RSP_CRC    | response CRC bits on the line
// RSP_END    | response end bit on the line

module sdio_host_cmd_phy #(
  parameter int RSP_TIMEOUT = 64
) (
  input  logic         sdio_clk_i,
  input  logic         rst_i,
  input  logic         cmd_stb_i,
  input  logic [5:0]   cmd_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [7:0]   rsps_len_i,
  input  logic         rsps_crc_en_i,
  output logic         busy_o,
  output logic         done_stb_o,
  output logic [127:0] rsps_o,
  output logic         rsps_crc_good_o,
  output logic         rsps_frame_err_o,
  output logic         rsps_timeout_o,
  input  logic         sdio_cmd_in_i,
  output logic         sdio_cmd_out_o,
  output logic         sdio_cmd_dir_o
);

  typedef enum logic [3:0] {
    IDLE, TX_CMD, TX_CRC, TX_END, RSP_WAIT, RSP_DIR, RSP_DATA, RSP_CRC, RSP_END
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(RSP_TIMEOUT);

  // One step of the x^7+x^3+1 LFSR.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  state_e         state_q;
  logic [39:0]    shift_q;
  logic [6:0]     crc_q;
  logic [6:0]     crc_rx_q;
  logic [7:0]     cnt_q;
  logic [7:0]     len_q;
  logic           crc_en_q;
  logic [127:0]   rsps_q;
  logic           crc_good_q;
  logic           frame_err_q;
  logic           timeout_q;
  logic           out_q;
  logic           dir_q;
  logic           busy_q;
  logic           done_q;

  logic [6:0]     crc_tx_d;
  logic [6:0]     crc_rx_d;
  logic [7:0]     len_d;

  always_comb begin
    crc_tx_d = crc7_step(crc_q, shift_q[39]);
    crc_rx_d = crc7_step(crc_q, sdio_cmd_in_i);
    len_d    = rsps_len_i[7] ? 8'd127 : rsps_len_i;
  end

  always_ff @(posedge sdio_clk_i) begin
    done_q <= 1'b0;
    if (rst_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      crc_q       <= '0;
      crc_rx_q    <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      crc_en_q    <= 1'b0;
      rsps_q      <= '0;
      crc_good_q  <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      out_q       <= 1'b1;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_q <= 1'b1;
          dir_q <= 1'b0;
          // The done_stb cycle still belongs to the finished transaction:
          // busy stays up and a coincident cmd_stb is not taken.
          if (cmd_stb_i && !done_q) begin
            // Start bit goes out now; shift_q[39] always holds the next bit to send.
            shift_q     <= {1'b1, cmd_i, cmd_arg_i, 1'b0};
            crc_q       <= crc7_step(7'd0, 1'b0);
            out_q       <= 1'b0;
            dir_q       <= 1'b1;
            cnt_q       <= '0;
            len_q       <= len_d;
            crc_en_q    <= rsps_crc_en_i;
            rsps_q      <= '0;
            crc_rx_q    <= '0;
            crc_good_q  <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= TX_CMD;
          end else begin
            busy_q <= 1'b0;
          end
        end
        TX_CMD: begin
          if (cnt_q == 8'd39) begin
            out_q   <= crc_q[6];
            crc_q   <= {crc_q[5:0], 1'b0};
            cnt_q   <= '0;
            state_q <= TX_CRC;
          end else begin
            out_q   <= shift_q[39];
            crc_q   <= crc_tx_d;
            shift_q <= {shift_q[38:0], 1'b0};
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        TX_CRC: begin
          if (cnt_q == 8'd6) begin
            out_q   <= 1'b1;
            state_q <= TX_END;
          end else begin
            out_q <= crc_q[6];
            crc_q <= {crc_q[5:0], 1'b0};
            cnt_q <= cnt_q + 8'd1;
          end
        end
        TX_END: begin
          out_q <= 1'b1;
          dir_q <= 1'b0;
          cnt_q <= '0;
          if (len_q == 8'd0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= RSP_WAIT;
          end
        end
        RSP_WAIT: begin
          // cnt_q == 0 marks the unsampled turnaround cycle.
          if (cnt_q == 8'd0) begin
            cnt_q <= 8'd1;
          end else if (!sdio_cmd_in_i) begin
            crc_q   <= crc7_step(7'd0, sdio_cmd_in_i);
            cnt_q   <= '0;
            state_q <= RSP_DIR;
          end else if (cnt_q >= TIMEOUT_CNT) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RSP_DIR: begin
          if (sdio_cmd_in_i) frame_err_q <= 1'b1;
          crc_q   <= crc_rx_d;
          cnt_q   <= '0;
          state_q <= RSP_DATA;
        end
        RSP_DATA: begin
          rsps_q <= {rsps_q[126:0], sdio_cmd_in_i};
          crc_q  <= crc_rx_d;
          if (cnt_q == len_q - 8'd1) begin
            cnt_q   <= '0;
            state_q <= RSP_CRC;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RSP_CRC: begin
          crc_rx_q <= {crc_rx_q[5:0], sdio_cmd_in_i};
          if (cnt_q == 8'd6) begin
            cnt_q   <= '0;
            state_q <= RSP_END;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RSP_END: begin
          if (!sdio_cmd_in_i) frame_err_q <= 1'b1;
          crc_good_q <= !crc_en_q || (crc_rx_q == crc_q);
          done_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          out_q   <= 1'b1;
          dir_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_stb_o       = done_q;
  assign rsps_o           = rsps_q;
  assign rsps_crc_good_o  = crc_good_q;
  assign rsps_frame_err_o = frame_err_q;
  assign rsps_timeout_o   = timeout_q;
  assign sdio_cmd_out_o   = out_q;
  assign sdio_cmd_dir_o   = dir_q;

endmodule

// File: tb/tb_sdio_host_cmd_phy.sv
// Bench for sdio_host_cmd_phy: a host link driver plus a device response model.
// Expected frames and status come from a reference that computes CRC7 by
// polynomial long division over the frame bits.
module tb_sdio_host_cmd_phy;
  localparam int RSP_TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_stb;
  logic [5:0]   cmd;
  logic [31:0]  cmd_arg;
  logic [7:0]   rsps_len;
  logic         rsps_crc_en;
  logic         busy;
  logic         done_stb;
  logic [127:0] rsps;
  logic         crc_good;
  logic         frame_err;
  logic         timeout;
  logic         cmd_in;
  logic         cmd_out;
  logic         cmd_dir;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [127:0] r;
    logic         g;
    logic         fe;
    logic         to;
    int           k;
  } exp_t;

  sdio_host_cmd_phy #(.RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .sdio_clk_i(clk), .rst_i(rst), .cmd_stb_i(cmd_stb), .cmd_i(cmd), .cmd_arg_i(cmd_arg),
    .rsps_len_i(rsps_len), .rsps_crc_en_i(rsps_crc_en), .busy_o(busy), .done_stb_o(done_stb),
    .rsps_o(rsps), .rsps_crc_good_o(crc_good), .rsps_frame_err_o(frame_err),
    .rsps_timeout_o(timeout), .sdio_cmd_in_i(cmd_in), .sdio_cmd_out_o(cmd_out),
    .sdio_cmd_dir_o(cmd_dir)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // Remainder of msg(x)*x^7 divided by x^7+x^3+1; msg[n-1] is the first bit sent.
  function automatic logic [6:0] crc7_ref(input logic [199:0] msg, input int n);
    logic [206:0] m;
    m = {7'd0, msg} << 7;
    for (int i = n + 6; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  function automatic logic [47:0] tx_ref(input logic [5:0] c, input logic [31:0] a);
    logic [199:0] msg;
    msg = {160'd0, 2'b01, c, a};
    return {2'b01, c, a, crc7_ref(msg, 40), 1'b1};
  endfunction

  function automatic exp_t model(input logic [7:0] len, input logic en, input bit respond,
                                 input bit dirb, input bit endb, input int flip,
                                 input logic [127:0] pay, input int dly);
    exp_t e;
    int L;
    L = (len > 8'd127) ? 127 : int'(len);
    e.r = '0; e.g = 1'b0; e.fe = 1'b0; e.to = 1'b0; e.k = 0;
    if (L == 0) begin
      e.k = 0;
    end else if (!respond) begin
      e.to = 1'b1;
      e.k  = RSP_TIMEOUT + 1;
    end else begin
      for (int j = 0; j < L; j++) e.r[j] = pay[j];
      e.g  = !en || (flip < 0);
      e.fe = dirb || !endb;
      e.k  = dly + L + 10;
    end
    return e;
  endfunction

  // Issues one command, captures the 48 driven bits, plays the device, and
  // returns at the negedge where done_stb is seen (kd = -1 if it never is).
  task automatic run_txn(input logic [5:0] c, input logic [31:0] a, input logic [7:0] len,
                         input logic en, input bit respond, input bit dirb, input bit endb,
                         input int flip, input logic [127:0] pay, input int dly, input int poke,
                         output logic [47:0] tx, output int dc, output int kd,
                         output logic [127:0] r, output logic g, output logic fe, output logic to);
    logic rq[$];
    logic [199:0] msg;
    logic [6:0] crc;
    int L;
    L = (len > 8'd127) ? 127 : int'(len);
    rq.delete();
    msg = '0;
    msg[0] = dirb;
    rq.push_back(1'b0);
    rq.push_back(dirb);
    for (int j = L - 1; j >= 0; j--) begin
      rq.push_back(pay[j]);
      msg = {msg[198:0], pay[j]};
    end
    crc = crc7_ref(msg, L + 2);
    for (int j = 0; j < 7; j++) rq.push_back(crc[6 - j] ^ (flip == j));
    rq.push_back(endb);

    @(negedge clk);
    cmd = c; cmd_arg = a; rsps_len = len; rsps_crc_en = en; cmd_in = 1'b1; cmd_stb = 1'b1;
    @(negedge clk);
    dc = 0;
    for (int i = 0; i < 48; i++) begin
      tx[47 - i] = cmd_out;
      if (cmd_dir === 1'b1) dc++;
      cmd_stb = (poke == i);
      cmd = (poke == i) ? ~c : c;
      @(negedge clk);
    end
    cmd_stb = 1'b0;
    kd = -1;
    r = 'x; g = 1'bx; fe = 1'bx; to = 1'bx;
    for (int k = 0; k < 400; k++) begin
      if (respond && k >= dly && (k - dly) < rq.size()) cmd_in = rq[k - dly];
      else cmd_in = 1'b1;
      cmd_stb = (poke == 48 + k);
      if (done_stb === 1'b1) begin
        kd = k; r = rsps; g = crc_good; fe = frame_err; to = timeout;
        break;
      end
      @(negedge clk);
    end
    cmd_stb = 1'b0;
    cmd_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_stb = 1'b0; cmd = '0; cmd_arg = '0; rsps_len = '0; rsps_crc_en = 1'b0;
    cmd_in = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (cmd_out !== 1'b1) begin n_err++; $display("FAIL reset_out: got %b want 1", cmd_out); end
    n_vec++; if (cmd_dir !== 1'b0) begin n_err++; $display("FAIL reset_dir: got %b want 0", cmd_dir); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done_stb !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_stb); end
    n_vec++; if (rsps !== 128'd0) begin n_err++; $display("FAIL reset_rsps: got %h want 0", rsps); end
    n_vec++; if ({crc_good, frame_err, timeout} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {crc_good, frame_err, timeout});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cmd0();
    logic [47:0] tx; int dc, kd; logic [127:0] r; logic g, fe, to;
    run_txn(6'd0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, -1, '0, 1, -1, tx, dc, kd, r, g, fe, to);
    n_vec++; if (tx !== 48'h40_0000_0000_95) begin n_err++; $display("FAIL cmd0_frame: got %h want 400000000095", tx); end
    n_vec++; if (dc != 48) begin n_err++; $display("FAIL cmd0_dir_cycles: got %0d want 48", dc); end
    n_vec++; if (kd != 0) begin n_err++; $display("FAIL cmd0_done_time: got %0d want 0", kd); end
    n_vec++; if (r !== 128'd0 || {g, fe, to} !== 3'b000) begin
      n_err++; $display("FAIL cmd0_status: got rsps=%h flags=%b want 0/000", r, {g, fe, to});
    end
    @(negedge clk);
    n_vec++; if (done_stb !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL cmd0_after: got done=%b busy=%b want 0 0", done_stb, busy);
    end
  endtask

  task automatic test_cmd8(input int flip);
    logic [47:0] tx; int dc, kd; logic [127:0] r; logic g, fe, to;
    logic [127:0] pay;
    int dly;
    pay = {90'd0, 6'd8, 32'h0000_01AA};
    dly = int'($urandom_range(1, 12));
    run_txn(6'd8, 32'h0000_01AA, 8'd38, 1'b1, 1'b1, 1'b0, 1'b1, flip, pay, dly, -1,
            tx, dc, kd, r, g, fe, to);
    n_vec++; if (tx[7:0] !== 8'h87) begin n_err++; $display("FAIL cmd8_crc_byte: got %h want 87", tx[7:0]); end
    n_vec++; if (r !== 128'h08_0000_01AA) begin n_err++; $display("FAIL cmd8_rsps: got %h want 08000001aa", r); end
    n_vec++; if (g !== (flip < 0)) begin n_err++; $display("FAIL cmd8_crc_good(flip=%0d): got %b want %b", flip, g, flip < 0); end
    n_vec++; if (fe !== 1'b0 || to !== 1'b0) begin n_err++; $display("FAIL cmd8_err_flags: got fe=%b to=%b want 0 0", fe, to); end
    n_vec++; if (kd != dly + 48) begin n_err++; $display("FAIL cmd8_done_time: got %0d want %0d", kd, dly + 48); end
  endtask

  task automatic test_timeout();
    logic [47:0] tx; int dc, kd; logic [127:0] r; logic g, fe, to;
    run_txn(6'd55, $urandom, 8'd38, 1'b1, 1'b0, 1'b0, 1'b1, -1, '0, 1, -1, tx, dc, kd, r, g, fe, to);
    n_vec++; if (kd != RSP_TIMEOUT + 1) begin n_err++; $display("FAIL timeout_time: got %0d want %0d", kd, RSP_TIMEOUT + 1); end
    n_vec++; if (to !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b want 1", to); end
    n_vec++; if (r !== 128'd0 || g !== 1'b0 || fe !== 1'b0) begin
      n_err++; $display("FAIL timeout_other: got rsps=%h g=%b fe=%b want 0 0 0", r, g, fe);
    end
  endtask

  task automatic test_r2();
    logic [47:0] tx; int dc, kd; logic [127:0] r; logic g, fe, to;
    logic [127:0] pay;
    exp_t e;
    pay = {$urandom, $urandom, $urandom, $urandom};
    e = model(8'd127, 1'b0, 1'b1, 1'b1, 1'b1, 2, pay, 3);
    run_txn(6'd2, $urandom, 8'd127, 1'b0, 1'b1, 1'b1, 1'b1, 2, pay, 3, -1, tx, dc, kd, r, g, fe, to);
    n_vec++; if (r !== e.r) begin n_err++; $display("FAIL r2_rsps: got %h want %h", r, e.r); end
    n_vec++; if (g !== 1'b1) begin n_err++; $display("FAIL r2_crc_good: got %b want 1", g); end
    n_vec++; if (fe !== 1'b1) begin n_err++; $display("FAIL r2_frame_err: got %b want 1", fe); end
    n_vec++; if (kd != e.k) begin n_err++; $display("FAIL r2_done_time: got %0d want %0d", kd, e.k); end
  endtask

  task automatic test_reset_mid_tx();
    bit seen;
    @(negedge clk);
    cmd = 6'd17; cmd_arg = $urandom; rsps_len = 8'd38; rsps_crc_en = 1'b1; cmd_stb = 1'b1;
    @(negedge clk);
    cmd_stb = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_tx_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if ({cmd_out, cmd_dir, busy, done_stb} !== 4'b1000) begin
      n_err++; $display("FAIL rst_tx_after: got out/dir/busy/done=%b want 1000", {cmd_out, cmd_dir, busy, done_stb});
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done_stb === 1'b1 || cmd_dir === 1'b1) seen = 1'b1;
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL rst_tx_quiet: got activity=1 want 0"); end
  endtask

  task automatic test_reset_mid_rx();
    bit seen;
    @(negedge clk);
    cmd = 6'd3; cmd_arg = $urandom; rsps_len = 8'd38; rsps_crc_en = 1'b1; cmd_stb = 1'b1;
    @(negedge clk);
    cmd_stb = 1'b0;
    repeat (48) @(negedge clk);
    @(negedge clk); cmd_in = 1'b0;
    @(negedge clk); cmd_in = 1'b0;
    repeat (10) begin @(negedge clk); cmd_in = 1'($urandom); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_rx_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if ({cmd_out, cmd_dir, busy, done_stb} !== 4'b1000) begin
      n_err++; $display("FAIL rst_rx_after: got out/dir/busy/done=%b want 1000", {cmd_out, cmd_dir, busy, done_stb});
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      cmd_in = 1'($urandom);
      @(negedge clk);
      if (done_stb === 1'b1) seen = 1'b1;
    end
    cmd_in = 1'b1;
    n_vec++; if (seen) begin n_err++; $display("FAIL rst_rx_no_done: got done seen=1 want 0"); end
  endtask

  task automatic test_busy_ignore();
    logic [47:0] tx; int dc, kd; logic [127:0] r; logic g, fe, to;
    logic [127:0] pay;
    logic [31:0] a;
    exp_t e;
    a = $urandom;
    pay = {$urandom, $urandom, $urandom, $urandom};
    e = model(8'd38, 1'b1, 1'b1, 1'b0, 1'b1, -1, pay, 4);
    run_txn(6'd13, a, 8'd38, 1'b1, 1'b1, 1'b0, 1'b1, -1, pay, 4, 20, tx, dc, kd, r, g, fe, to);
    n_vec++; if (tx !== tx_ref(6'd13, a)) begin n_err++; $display("FAIL busy_tx_poke: got %h want %h", tx, tx_ref(6'd13, a)); end
    n_vec++; if (r !== e.r || g !== e.g || kd != e.k) begin
      n_err++; $display("FAIL busy_tx_poke_rsp: got %h %b %0d want %h %b %0d", r, g, kd, e.r, e.g, e.k);
    end
    run_txn(6'd13, a, 8'd38, 1'b1, 1'b1, 1'b0, 1'b1, -1, pay, 4, 48 + 4 + 10, tx, dc, kd, r, g, fe, to);
    n_vec++; if (r !== e.r || g !== e.g || fe !== e.fe || kd != e.k) begin
      n_err++; $display("FAIL busy_rx_poke: got %h %b %b %0d want %h %b %b %0d", r, g, fe, kd, e.r, e.g, e.fe, e.k);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] tx; int dc, kd; logic [127:0] r; logic g, fe, to;
    int n;
    run_txn(6'd0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, -1, '0, 1, -1, tx, dc, kd, r, g, fe, to);
    n_vec++; if (kd != 0) begin n_err++; $display("FAIL b2b_first_done: got %0d want 0", kd); end
    cmd = 6'd5; cmd_arg = $urandom; rsps_len = 8'd0; cmd_stb = 1'b1;
    @(negedge clk);
    n_vec++; if (cmd_dir !== 1'b0) begin n_err++; $display("FAIL b2b_stb_with_done: got dir=%b want 0", cmd_dir); end
    @(negedge clk);
    cmd_stb = 1'b0;
    n_vec++; if ({cmd_dir, cmd_out} !== 2'b10) begin
      n_err++; $display("FAIL b2b_stb_after_done: got dir/out=%b want 10", {cmd_dir, cmd_out});
    end
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done_stb === 1'b1) begin n = i; break; end
    end
    n_vec++; if (n != 48) begin n_err++; $display("FAIL b2b_second_done: got %0d want 48", n); end
  endtask

  task automatic test_random(input int iters);
    logic [47:0] tx; int dc, kd; logic [127:0] r; logic g, fe, to;
    logic [5:0] c; logic [31:0] a; logic [7:0] len; logic en;
    bit respond, dirb, endb; int flip, dly, sel;
    logic [127:0] pay;
    exp_t e;
    for (int it = 0; it < iters; it++) begin
      c = 6'($urandom); a = $urandom; en = 1'($urandom);
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: len = 8'd0;
        1: len = 8'd38;
        2: len = 8'd127;
        5: len = 8'($urandom_range(128, 255));
        default: len = 8'($urandom_range(1, 127));
      endcase
      respond = ($urandom_range(0, 7) != 0);
      dirb = ($urandom_range(0, 5) == 0);
      endb = ($urandom_range(0, 5) != 0);
      flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      pay = {$urandom, $urandom, $urandom, $urandom};
      dly = int'($urandom_range(1, 20));
      e = model(len, en, respond, dirb, endb, flip, pay, dly);
      run_txn(c, a, len, en, respond, dirb, endb, flip, pay, dly, -1, tx, dc, kd, r, g, fe, to);
      n_vec++; if (tx !== tx_ref(c, a) || dc != 48) begin
        n_err++; $display("FAIL rnd%0d_tx: got %h/%0d want %h/48", it, tx, dc, tx_ref(c, a));
      end
      n_vec++; if (kd != e.k) begin n_err++; $display("FAIL rnd%0d_done_time: got %0d want %0d", it, kd, e.k); end
      n_vec++; if (r !== e.r) begin n_err++; $display("FAIL rnd%0d_rsps: got %h want %h", it, r, e.r); end
      n_vec++; if ({g, fe, to} !== {e.g, e.fe, e.to}) begin
        n_err++; $display("FAIL rnd%0d_flags: got g/fe/to=%b want %b", it, {g, fe, to}, {e.g, e.fe, e.to});
      end
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8(-1);
    test_cmd8(3);
    test_timeout();
    test_r2();
    test_reset_mid_tx();
    test_reset_mid_rx();
    test_cmd0();
    test_busy_ignore();
    test_back_to_back();
    test_random(25);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
